// File: rtl/dive_command_sequencer.sv
// dive_command_sequencer: parses "forward|up|down N" ASCII lines into
// one-cycle solver commands, preceded by a clear command.
// Ports: clk, reset (async, active-high)
//        in_valid/in_ready/in_data/in_last : byte stream input
//        cmd_enable/cmd_direction/cmd_value : solver command (registered)
//        done, error : sticky status flags
module dive_command_sequencer #(
   parameter int VALUE_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [7:0]             in_data,
   input  logic                   in_last,
   output logic                   cmd_enable,
   output logic [1:0]             cmd_direction,
   output logic [VALUE_WIDTH-1:0] cmd_value,
   output logic                   done,
   output logic                   error
);

   typedef enum logic [2:0] {
      S_INIT, S_LINE, S_WORD, S_NUM, S_ISSUE, S_ERR, S_DONE
   } state_t;

   state_t                 r_state, w_nx_state;
   logic [1:0]             r_dir, w_nx_dir;
   logic [VALUE_WIDTH-1:0] r_acc, w_nx_acc;
   logic                   r_have, w_nx_have;
   logic                   r_last, w_nx_last;
   logic                   r_ready, w_nx_ready;
   logic                   r_en, w_nx_en;
   logic [1:0]             r_cdir, w_nx_cdir;
   logic [VALUE_WIDTH-1:0] r_cval, w_nx_cval;
   logic                   r_done, r_err;

   logic                   w_xfer;
   logic                   w_is_digit;
   logic                   w_is_lower;
   logic                   w_is_lf;
   logic                   w_is_cr;
   logic [VALUE_WIDTH-1:0] w_acc_dig;

   assign w_xfer     = in_valid & r_ready;
   assign w_is_digit = (in_data >= 8'h30) && (in_data <= 8'h39);
   assign w_is_lower = (in_data >= 8'h61) && (in_data <= 8'h7a);
   assign w_is_lf    = (in_data == 8'h0a);
   assign w_is_cr    = (in_data == 8'h0d);
   // acc*10 + digit, wrapping at the register width
   assign w_acc_dig  = (r_acc << 3) + (r_acc << 1)
                     + {{(VALUE_WIDTH-4){1'b0}}, in_data[3:0]};

   always_comb begin
      w_nx_state = r_state;
      w_nx_dir   = r_dir;
      w_nx_acc   = r_acc;
      w_nx_have  = r_have;
      w_nx_last  = r_last;
      w_nx_en    = 1'b0;
      w_nx_cdir  = r_cdir;
      w_nx_cval  = r_cval;
      unique case (r_state)
         S_INIT: begin
            w_nx_state = S_LINE;
            w_nx_en    = 1'b1;
            w_nx_cdir  = 2'b11;
            w_nx_cval  = '0;
            w_nx_last  = 1'b0;
         end
         S_LINE: begin
            if (w_xfer) begin
               if (in_data == 8'h66 || in_data == 8'h75 ||
                   in_data == 8'h64) begin
                  w_nx_dir   = (in_data == 8'h66) ? 2'b00 :
                               (in_data == 8'h75) ? 2'b01 : 2'b10;
                  w_nx_state = in_last ? S_DONE : S_WORD;
               end else if (w_is_lf || w_is_cr) begin
                  if (in_last) w_nx_state = S_DONE;
               end else begin
                  w_nx_state = S_ERR;
                  w_nx_last  = in_last;
               end
            end
         end
         S_WORD: begin
            if (w_xfer) begin
               if (in_last) begin
                  w_nx_state = S_ERR;
                  w_nx_last  = 1'b1;
               end else if (in_data == 8'h20) begin
                  w_nx_acc   = '0;
                  w_nx_have  = 1'b0;
                  w_nx_state = S_NUM;
               end else if (!w_is_lower) begin
                  w_nx_state = S_ERR;
               end
            end
         end
         S_NUM: begin
            if (w_xfer) begin
               if (w_is_digit) begin
                  w_nx_acc  = w_acc_dig;
                  w_nx_have = 1'b1;
               end
               if (!(w_is_digit || w_is_cr || w_is_lf)) begin
                  w_nx_state = S_ERR;
                  w_nx_last  = in_last;
               end else if (in_last || w_is_lf) begin
                  // line terminator (or end of stream) closes the number
                  if (r_have || w_is_digit) begin
                     w_nx_state = S_ISSUE;
                     w_nx_en    = 1'b1;
                     w_nx_cdir  = r_dir;
                     w_nx_cval  = w_is_digit ? w_acc_dig : r_acc;
                  end else begin
                     w_nx_state = S_ERR;
                  end
                  w_nx_last = in_last;
               end
            end
         end
         S_ISSUE: begin
            w_nx_have  = 1'b0;
            w_nx_state = r_last ? S_DONE : S_LINE;
         end
         S_ERR: begin
            if (r_last || (w_xfer && in_last))
               w_nx_state = S_DONE;
         end
         S_DONE: w_nx_state = S_DONE;
         default: w_nx_state = S_INIT;
      endcase
   end

   // ERROR with a pending last byte drains nothing more
   assign w_nx_ready = (w_nx_state == S_LINE) || (w_nx_state == S_WORD) ||
                       (w_nx_state == S_NUM) ||
                       ((w_nx_state == S_ERR) && !w_nx_last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_INIT;
         r_dir   <= '0;
         r_acc   <= '0;
         r_have  <= 1'b0;
         r_last  <= 1'b0;
         r_ready <= 1'b0;
         r_en    <= 1'b0;
         r_cdir  <= '0;
         r_cval  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nx_state;
         r_dir   <= w_nx_dir;
         r_acc   <= w_nx_acc;
         r_have  <= w_nx_have;
         r_last  <= w_nx_last;
         r_ready <= w_nx_ready;
         r_en    <= w_nx_en;
         r_cdir  <= w_nx_cdir;
         r_cval  <= w_nx_cval;
         r_done  <= (w_nx_state == S_DONE);
         r_err   <= r_err | (w_nx_state == S_ERR);
      end
   end

   assign in_ready      = r_ready;
   assign cmd_enable    = r_en;
   assign cmd_direction = r_cdir;
   assign cmd_value     = r_cval;
   assign done          = r_done;
   assign error         = r_err;

endmodule

// File: tb/tb_dive_command_sequencer.sv
// tb_dive_command_sequencer: directed streams with a command scoreboard
// and a small dive-solver model on the observed commands.
module tb_dive_command_sequencer;

   localparam int VW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [7:0]    in_data = 8'h00;
   logic          in_last = 1'b0;
   logic          cmd_enable;
   logic [1:0]    cmd_direction;
   logic [VW-1:0] cmd_value;
   logic          done;
   logic          error;

   int checks = 0;
   int failures = 0;
   logic [VW+1:0] q[$];
   logic [VW+1:0] exp_c;
   logic          prev_en = 1'b0;
   longint        pos_h = 0;
   longint        pos_d = 0;

   dive_command_sequencer #(.VALUE_WIDTH(VW)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_last(in_last),
      .cmd_enable(cmd_enable), .cmd_direction(cmd_direction),
      .cmd_value(cmd_value), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Scoreboard side: compare every command strobe against the queue
   always @(negedge clk) begin
      if (!reset) begin
         if (cmd_enable) begin
            checks++;
            assert (!prev_en) else begin
               failures++;
               $error("FAIL back_to_back cmd_enable got=1 want=0");
            end
            checks++;
            assert (q.size() > 0) else begin
               failures++;
               $error("FAIL unexpected_cmd got=%b/%0d want=none",
                      cmd_direction, cmd_value);
            end
            if (q.size() > 0) begin
               exp_c = q.pop_front();
               checks++;
               assert ({cmd_direction, cmd_value} === exp_c) else begin
                  failures++;
                  $error("FAIL cmd got=%b/%0d want=%b/%0d",
                         cmd_direction, cmd_value,
                         exp_c[VW+1:VW], exp_c[VW-1:0]);
               end
            end
            unique case (cmd_direction)
               2'b00: pos_h += longint'(cmd_value);
               2'b01: pos_d -= longint'(cmd_value);
               2'b10: pos_d += longint'(cmd_value);
               default: begin pos_h = 0; pos_d = 0; end
            endcase
         end
         prev_en = cmd_enable;
      end else begin
         prev_en = 1'b0;
      end
   end

   task automatic push(input logic [1:0] d, input logic [VW-1:0] v);
      q.push_back({d, v});
   endtask

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] want);
      checks++;
      assert (got === want) else begin
         failures++;
         $error("FAIL %s got=%0d want=%0d", tag, got, want);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      in_valid = 1'b0;
      in_last = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_outs",
          {in_ready, cmd_enable, cmd_direction, cmd_value, done, error}, 0);
      q.delete();
      push(2'b11, '0);
      reset = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      in_valid = 1'b1;
      in_data = b;
      in_last = last;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_timeout", 0, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 8'hxx;
      in_last = 1'bx;
   endtask

   task automatic send_str(input string s, input bit gaps,
                           input bit last_end);
      for (int i = 0; i < s.len(); i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
         send_byte(s[i], last_end && (i == s.len() - 1));
      end
   endtask

   task automatic finish_test(input string tag, input bit want_err);
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      chk({tag, "_done"}, done, 1);
      chk({tag, "_error"}, error, want_err);
      chk({tag, "_qempty"}, q.size(), 0);
   endtask

   initial begin
      // 1: AoC example, in_last on final newline
      do_reset();
      push(2'b00, 5); push(2'b10, 5); push(2'b00, 8);
      push(2'b01, 3); push(2'b10, 8); push(2'b00, 2);
      send_str("forward 5\ndown 5\nforward 8\nup 3\ndown 8\nforward 2\n",
               0, 1);
      finish_test("aoc", 0);
      chk("aoc_product", pos_h * pos_d, 150);

      // 2: CRLF, gaps, no trailing newline
      do_reset();
      push(2'b00, 5); push(2'b10, 5); push(2'b00, 8);
      push(2'b01, 3); push(2'b10, 8); push(2'b00, 2);
      send_str({"forward 5\r\ndown 5\r\nforward 8\r\n",
                "up 3\r\ndown 8\r\nforward 2"}, 1, 1);
      finish_test("crlf", 0);
      chk("crlf_product", pos_h * pos_d, 150);

      // 3: modulo wrap and zero value
      do_reset();
      push(2'b01, 1); push(2'b10, 0);
      send_str("up 4294967297\ndown 0\n", 0, 1);
      finish_test("wrap", 0);

      // 4: bad keyword mid-stream
      do_reset();
      push(2'b00, 3);
      send_str("forward 3\nj", 0, 0);
      chk("bad_err_now", error, 1);
      send_str("ump 2\ndown 1\n", 1, 1);
      finish_test("bad", 1);

      // 5a: empty lines
      do_reset();
      push(2'b00, 7);
      send_str("\n\nforward 7\n\n", 1, 1);
      finish_test("empty", 0);

      // 5b: missing number
      do_reset();
      send_str("down \n", 0, 1);
      finish_test("nonum", 1);

      // 6: async reset mid-line
      do_reset();
      send_str("forward 1", 0, 0);
      #2 reset = 1'b1;
      #1;
      chk("async_rst",
          {in_ready, cmd_enable, cmd_direction, cmd_value, done, error}, 0);
      @(negedge clk);
      q.delete();
      push(2'b11, '0);
      reset = 1'b0;
      push(2'b01, 9);
      send_str("up 9\n", 0, 1);
      finish_test("rstmid", 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=running want=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dive_command_sequencer.md
Name: dive_command_sequencer

Overview:
- Front-end controller for the dive position solver.
- Consumes the puzzle input as an ASCII byte stream over a valid/ready handshake and parses lines of the form "forward N", "up N" and "down N".
- Issues exactly one single-cycle solver command (enable, direction, value) per valid line.
- Issues a leading clear command, then flags completion or a format error.

Parameters:
VALUE_WIDTH, 32, width of parsed magnitude and cmd_value; must match solver value width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  in_data/in_last valid this cycle
in_ready  output  1  sequencer accepts byte this cycle (transfer = in_valid & in_ready)
in_data  input  8  ASCII input byte
in_last  input  1  marks final byte of the stream
cmd_enable  output  1  one-cycle command strobe to solver
cmd_direction  output  2  00 forward, 01 up, 10 down, 11 clear
cmd_value  output  VALUE_WIDTH  command magnitude (0 for clear)
done  output  1  stream fully processed; sticky until reset
error  output  1  format error seen; sticky until reset

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock. While reset is high all outputs are 0 and the FSM is forced to INIT; the accumulator and direction register are cleared.
- Reset mid-line or mid-command: any partial line is discarded and no command is emitted for it.
- All outputs are registered. Commands appear on the cycle after the accepting edge.
- INIT: in_ready=0. On the first cycle after reset is released, assert cmd_enable=1, cmd_direction=11, cmd_value=0 for exactly one cycle, then go to LINE_START.
- LINE_START (in_ready=1):
  - 'f' sets dir=00, 'u' sets dir=01, 'd' sets dir=10; go to WORD.
  - 0x0A and 0x0D are ignored, so empty lines produce no command.
  - Any other byte goes to ERROR.
- WORD (in_ready=1):
  - Lowercase letters a-z are skipped (spelling is not checked).
  - 0x20 clears the accumulator and goes to NUMBER.
  - Any other byte goes to ERROR.
- NUMBER (in_ready=1):
  - Digit '0'-'9': acc = acc*10 + digit, modulo 2^VALUE_WIDTH (wrap, no saturation); set the have_digit flag.
  - 0x0D is ignored.
  - 0x0A with have_digit goes to ISSUE; 0x0A without a digit goes to ERROR.
  - Any other byte goes to ERROR.
- ISSUE: in_ready=0. For one cycle assert cmd_enable=1, cmd_direction=dir, cmd_value=acc. Then go to LINE_START, or to DONE if the issuing line ended with in_last.
- in_last handling: evaluated together with the byte it accompanies.
  - In NUMBER, a digit byte with in_last and a completed number goes to ISSUE, then DONE. A missing final newline is legal.
  - In LINE_START, any in_last byte that is not itself an error goes to DONE.
  - In WORD, in_last, or in NUMBER with no digit yet, goes to ERROR, then DONE.
- ERROR: error=1. in_ready=1 and all bytes are drained with no further commands. A byte carrying in_last goes to DONE.
- DONE: in_ready=0, done=1, cmd_enable=0. Only reset leaves DONE.
- Throughput: one byte per cycle, except one bubble per issued command. in_valid gaps are permitted anywhere. in_data and in_last are sampled only on a transfer.
- cmd_enable is never high for two consecutive cycles. cmd_value and cmd_direction hold their last values while cmd_enable=0.

Test Plan:
- AoC example "forward 5\ndown 5\nforward 8\nup 3\ndown 8\nforward 2\n" (in_last on final '\n') -> clear command, then (00,5),(10,5),(00,8),(01,3),(10,8),(00,2) in order; done=1, error=0; attached solver reads 150.
- Same stream without the trailing newline, in_last on '2', plus random in_valid gaps and "\r\n" line endings -> identical command sequence; done=1; no command emitted twice.
- "up 4294967297\n" -> one command (01,1) from modulo-2^32 wrap; "down 0\n" -> command (10,0).
- "forward 3\njump 2\ndown 1\n" -> clear, (00,3), then error=1 on 'j'; no further commands; done=1 after the in_last byte.
- "\n\nforward 7\n\n" -> exactly one data command (00,7); "down \n" -> error=1, no command.
- Reset asserted mid-"forward 12" -> outputs 0 asynchronously. After release, a new clear command is issued and the next full line "up 9\n" yields (01,9) only.
